// File: rtl/uart_rx_pkg.sv
// Shared types and default sizing for the UART receiver.
package uart_rx_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_WIDTH_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line,
    output logic line_sync
);

    logic meta;

    // Resolve metastability over two stages before anyone looks at the line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            meta      <= line;
            line_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit detect, mid-bit sampling, optional even parity,
// stop-bit check and a single-entry valid/ready output register.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | half a bit in; confirm the start bit is still low
// DATA      | sampling DATA_WIDTH data bits, LSB first
// PARITY    | sampling the even-parity bit
// STOP      | sampling the stop bit; the word is committed at this sample
// WAIT_IDLE | stop bit was low; wait for the line to return high
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_WIDTH - 1);

    logic                  rx_s;
    logic                  rx_prev;
    logic [1:0]            warm;
    state_t                state;
    logic [15:0]           cnt;
    logic [3:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_err;
    logic                  sample;
    logic                  fall;
    logic                  wr;

    uart_sync u_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .line      (rx_i),
        .line_sync (rx_s)
    );

    // rx_prev only follows rx_s once the synchronizer has flushed its reset
    // value, so a line already low at reset release never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            warm    <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            if (warm[1]) begin
                rx_prev <= rx_s;
            end
        end
    end

    assign fall   = rx_prev & ~rx_s;
    assign sample = (cnt == 16'd0);
    assign wr     = (state == STOP) && sample;
    assign busy_o = (state != IDLE);

    // Frame FSM with a down-counting bit timer; terminal count marks each sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 4'd0;
            shreg   <= '0;
            par_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        cnt     <= HALF_LOAD;
                        bit_idx <= 4'd0;
                        par_err <= 1'b0;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!rx_s) begin
                            state <= DATA;
                            cnt   <= FULL_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        cnt   <= FULL_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                PARITY: begin
                    if (sample) begin
                        par_err <= (^shreg) ^ rx_s;
                        cnt     <= FULL_LOAD;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (sample) begin
                        state <= rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: commit at the stop sample unless an unread word is
    // still held, in which case the new word is dropped and overrun pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (wr) begin
                if (valid_o && !ready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    data_o       <= shreg;
                    parity_err_o <= PARITY_EN & par_err;
                    frame_err_o  <= ~rx_s;
                    valid_o      <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver without parity (a), one with (b).
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b, ready;
    logic [7:0] data_a, data_b;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a),
        .ready_i(ready), .parity_err_o(perr_a), .frame_err_o(ferr_a),
        .overrun_o(ovr_a), .busy_o(busy_a));

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .data_o(data_b), .valid_o(valid_b),
        .ready_i(ready), .parity_err_o(perr_b), .frame_err_o(ferr_b),
        .overrun_o(ovr_b), .busy_o(busy_b));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake capture, valid rise timing and overrun counting.
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    int   rise_a = 0, rise_b = 0, nrise_a = 0, novr_a = 0;
    logic vprev_a = 1'b0, vprev_b = 1'b0;

    always @(negedge clk) begin
        if (valid_a && ready) q_a.push_back({perr_a, ferr_a, data_a});
        if (valid_b && ready) q_b.push_back({perr_b, ferr_b, data_b});
        if (valid_a && !vprev_a) begin
            rise_a = cyc;
            nrise_a++;
        end
        if (valid_b && !vprev_b) rise_b = cyc;
        vprev_a = valid_a;
        vprev_b = valid_b;
        if (ovr_a) novr_a++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic bit_out(input bit sel, input logic v);
        set_rx(sel, v);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input bit pbit, input bit stopb, output int fall_cyc);
        @(posedge clk);
        #1;
        set_rx(sel, 1'b0);
        fall_cyc = cyc;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) bit_out(sel, d[i]);
        if (use_par) bit_out(sel, pbit);
        bit_out(sel, stopb);
        if (!stopb) begin
            repeat (40) @(posedge clk);
            #1;
        end
        set_rx(sel, 1'b1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] d;
        bit         pbit;
        bit         stopb;
        logic [7:0] exp_d;
        bit         exp_p;
        bit         exp_f;
    } vec_t;

    vec_t       vecs[10];
    int         fc, nq, lat, nr0, novr0;
    logic [9:0] w;
    logic [7:0] v5a;

    initial begin
        vecs[0] = '{0, 8'hA5, 0, 1, 8'hA5, 0, 0};
        vecs[1] = '{0, 8'h3C, 0, 0, 8'h3C, 0, 1};
        vecs[2] = '{0, 8'h81, 0, 1, 8'h81, 0, 0};
        vecs[3] = '{1, 8'h07, 0, 1, 8'h07, 1, 0};
        vecs[4] = '{1, 8'h07, 1, 1, 8'h07, 0, 0};
        vecs[5] = '{0, 8'h00, 0, 1, 8'h00, 0, 0};
        vecs[6] = '{0, 8'hFF, 0, 1, 8'hFF, 0, 0};
        vecs[7] = '{1, 8'hC3, 0, 1, 8'hC3, 0, 0};
        vecs[8] = '{1, 8'h01, 1, 0, 8'h01, 0, 1};
        vecs[9] = '{1, 8'h80, 0, 1, 8'h80, 1, 0};

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_a", int'(valid_a), 0);
        check("rst_data_a",  int'(data_a),  0);
        check("rst_busy_a",  int'(busy_a),  0);
        check("rst_ovr_a",   int'(ovr_a),   0);
        check("rst_flags_a", int'({perr_a, ferr_a}), 0);
        check("rst_valid_b", int'(valid_b), 0);
        check("rst_busy_b",  int'(busy_b),  0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            q_a.delete();
            q_b.delete();
            send_frame(vecs[i].sel, vecs[i].d, vecs[i].sel, vecs[i].pbit, vecs[i].stopb, fc);
            if (vecs[i].sel) begin
                nq  = q_b.size();
                lat = rise_b - fc;
                w   = (nq > 0) ? q_b.pop_front() : 10'h3FF;
            end else begin
                nq  = q_a.size();
                lat = rise_a - fc;
                w   = (nq > 0) ? q_a.pop_front() : 10'h3FF;
            end
            check($sformatf("vec%0d_words", i), nq, 1);
            check($sformatf("vec%0d_data", i), int'(w[7:0]), int'(vecs[i].exp_d));
            check($sformatf("vec%0d_parity_err", i), int'(w[9]), int'(vecs[i].exp_p));
            check($sformatf("vec%0d_frame_err", i), int'(w[8]), int'(vecs[i].exp_f));
            check($sformatf("vec%0d_latency", i), lat, vecs[i].sel ? 171 : 155);
        end

        // Short low glitch: start bit rejected, no word.
        nr0 = nrise_a;
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_a = 1'b1;
        check("glitch_busy_mid", int'(busy_a), 1);
        repeat (30) @(posedge clk);
        #1;
        check("glitch_busy_end", int'(busy_a), 0);
        check("glitch_no_word", nrise_a - nr0, 0);

        // Overrun: consumer stalled across two frames.
        ready = 1'b0;
        novr0 = novr_a;
        q_a.delete();
        send_frame(0, 8'h11, 0, 0, 1, fc);
        check("ovr_valid_first", int'(valid_a), 1);
        check("ovr_data_first", int'(data_a), 'h11);
        send_frame(0, 8'h22, 0, 0, 1, fc);
        check("ovr_data_kept", int'(data_a), 'h11);
        check("ovr_valid_kept", int'(valid_a), 1);
        check("ovr_pulses", novr_a - novr0, 1);
        check("ovr_no_handshake", q_a.size(), 0);
        @(posedge clk);
        #1;
        ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_at_hs", int'(valid_a), 1);
        @(posedge clk);
        #1;
        check("ovr_valid_after_hs", int'(valid_a), 0);
        nq = q_a.size();
        w  = (nq > 0) ? q_a.pop_front() : 10'h3FF;
        check("ovr_hs_words", nq, 1);
        check("ovr_hs_data", int'(w[7:0]), 'h11);

        // Reset during data bit 4, then line held low across release.
        v5a = 8'h5A;
        nr0 = nrise_a;
        @(posedge clk);
        #1;
        bit_out(0, 1'b0);
        for (int i = 0; i < 4; i++) bit_out(0, v5a[i]);
        rx_a = v5a[4];
        repeat (8) @(posedge clk);
        #1;
        check("rstmid_busy_before", int'(busy_a), 1);
        rst_n = 1'b0;
        rx_a  = 1'b0;
        #1;
        check("rstmid_data",  int'(data_a),  0);
        check("rstmid_valid", int'(valid_a), 0);
        check("rstmid_busy",  int'(busy_a),  0);
        check("rstmid_ovr",   int'(ovr_a),   0);
        check("rstmid_flags", int'({perr_a, ferr_a}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("lowline_busy", int'(busy_a), 0);
        check("lowline_no_word", nrise_a - nr0, 0);
        rx_a = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        q_a.delete();
        send_frame(0, 8'h5A, 0, 0, 1, fc);
        nq = q_a.size();
        w  = (nq > 0) ? q_a.pop_front() : 10'h3FF;
        check("post_rst_words", nq, 1);
        check("post_rst_data", int'(w[7:0]), 'h5A);
        check("post_rst_flags", int'(w[9:8]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit; legal range 4..65535; even values only.
REQ-002 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_EN, default 0, 1 = even parity bit between data and stop bits.
REQ-004 Port clk_i  in  1  sole clock; every flop is rising-edge.
REQ-005 Port rst_ni  in  1  asynchronous active-low reset.
REQ-006 Port rx_i  in  1  serial line from remote UART; asynchronous to clk_i; idle high.
REQ-007 Port data_o  out  DATA_WIDTH  received word, LSB = first bit on the line.
REQ-008 Port valid_o  out  1  data_o, parity_err_o and frame_err_o hold a valid word.
REQ-009 Port ready_i  in  1  consumer accepts the word when valid_o and ready_i are both high.
REQ-010 Port parity_err_o  out  1  received parity mismatched; qualified by valid_o; always 0 when PARITY_EN=0.
REQ-011 Port frame_err_o  out  1  stop bit sampled low; qualified by valid_o.
REQ-012 Port overrun_o  out  1  one-cycle pulse: a completed frame was dropped.
REQ-013 Port busy_o  out  1  high in every FSM state except IDLE.

Function
REQ-014 rx_i SHALL pass through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-016 IDLE -> START on a falling edge of rx_s (1 then 0); this cycle is the detection cycle T0.
REQ-017 A bit counter SHALL produce sample instants at T0+CLKS_PER_BIT/2, then every CLKS_PER_BIT cycles.
REQ-018 START: at the first sample, rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch rejected; no output, no error).
REQ-019 DATA: shift in DATA_WIDTH samples, LSB first; after the last sample -> PARITY if PARITY_EN, else STOP.
REQ-020 PARITY: one sample; parity_err SHALL be set when XOR of the data bits and the parity bit is 1.
REQ-021 STOP: one sample; rx_s=1 -> IDLE; rx_s=0 -> set frame_err and go to WAIT_IDLE.
REQ-022 WAIT_IDLE -> IDLE only when rx_s=1, so a held-low line is never read as a new start bit.
REQ-023 The word and both error flags SHALL be written to the output register, and valid_o raised, in the cycle after the stop sample.
REQ-024 Frames with parity or framing errors SHALL still be delivered, with the matching flag set.
REQ-025 valid_o SHALL stay high and data_o/flags SHALL stay stable until the ready_i handshake.
REQ-026 valid_o SHALL fall in the cycle after the handshake, unless a new word is written in that same cycle; then valid_o stays high with the new word.
REQ-027 A word completing while valid_o=1 and ready_i=0 SHALL be dropped, the old word kept, and overrun_o pulsed for one cycle.
REQ-028 ready_i SHALL have no effect while valid_o=0.
REQ-029 Reception of the next frame SHALL proceed regardless of the output register state.

Reset
REQ-030 While rst_ni=0: FSM=IDLE, counters=0, synchronizer=1, data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no output.
REQ-032 After reset release, a line already low SHALL NOT start a frame until it has been seen high.

Structure
REQ-033 Package uart_rx_pkg SHALL hold the FSM state enum and the default CLKS_PER_BIT/DATA_WIDTH constants.
REQ-034 The synchronizer SHALL be a sub-module named uart_sync; everything else lives in uart_rx.

Verification (CLKS_PER_BIT=16, DATA_WIDTH=8, ready_i=1 unless stated)
REQ-035 Send 0xA5 with stop=1, PARITY_EN=0 -> data_o=0xA5, flags=0, valid_o rises exactly 155 cycles after the rx_i falling edge (2 sync + 152 + 1).
REQ-036 Drive rx_i low for 5 cycles, then high -> no valid_o, busy_o returns low, FSM back to IDLE.
REQ-037 Send 0x3C with stop=0, hold line low 40 cycles, then send 0x81 -> first word 0x3C with frame_err_o=1; second word 0x81 with no flags.
REQ-038 PARITY_EN=1: send 0x07 with parity bit 0 -> parity_err_o=1; send 0x07 with parity bit 1 -> parity_err_o=0.
REQ-039 ready_i=0; send 0x11 then 0x22 -> data_o stays 0x11 and overrun_o pulses once; raising ready_i -> valid_o falls next cycle.
REQ-040 Assert rst_ni low during data bit 4 of a frame -> all outputs at reset values; next full frame 0x5A received correctly.
